main_memory: RTL and testbench

- Word-addressed main-memory responder: the far end of the CPU's main-memory control interface.
- Accepts the read address, write address, write data and write enable driven by the memory-control logic.
- Returns read data after a fixed pipeline latency.
- After reset, clears its own contents before advertising readiness.
- Sits between the CPU core's memory-control block and the instruction/data store.

---
 rtl/main_memory.sv | 75 +++++++
 tb/tb_main_memory.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/main_memory.sv
// main_memory: word-addressed memory responder that self-clears after reset, then serves pipelined reads.
// Optional range checking of addresses is built when MAIN_MEMORY_BOUNDS_CHECK_EN is defined.
module main_memory #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] read_address,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic [31:0] read_data,
  output logic        read_data_valid,
  output logic        mem_ready,
  output logic        misaligned_error,
  output logic        bounds_error
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic {INIT, READY} state_t;
  state_t state, state_d;
  logic [AW-1:0] cnt;
  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] ridx, widx;
  logic ready, rd_oob, wr_oob, rd_mis, wr_mis, wr_ok;
  logic [31:0] rd_word;
  logic [READ_LATENCY-1:0] vld;
  logic [31:0] dat [READ_LATENCY];
  assign ready = state == READY;
  assign ridx = read_address[AW+1:2];
  assign widx = write_address[AW+1:2];
  assign rd_mis = |read_address[1:0];
  assign wr_mis = |write_address[1:0];
`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
  assign rd_oob = |read_address[31:AW+2];
  assign wr_oob = |write_address[31:AW+2];
`else
  logic unused_upper;
  assign unused_upper = ^{read_address[31:AW+2], write_address[31:AW+2]};
  assign rd_oob = 1'b0;
  assign wr_oob = 1'b0;
`endif
  assign wr_ok = ready && write_enable && !wr_mis && !wr_oob;
  // Write-first bypass so a same-cycle read of the word being stored sees the new value
  assign rd_word = rd_oob ? '0 : (wr_ok && widx == ridx) ? write_data : mem[ridx];
  always_comb state_d = (state == INIT && &cnt) ? READY : state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
      vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat[i] <= '0;
      misaligned_error <= 1'b0;
      bounds_error <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= (state == INIT) ? cnt + 1'b1 : cnt;
      vld[0] <= ready;
      dat[0] <= ready ? rd_word : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
      misaligned_error <= ready && (rd_mis || (write_enable && wr_mis));
      bounds_error <= ready && (rd_oob || (write_enable && wr_oob));
    end
  end
  always_ff @(posedge clk) begin
    if (state == INIT) mem[cnt] <= '0;
    else if (wr_ok) mem[widx] <= write_data;
  end
  assign read_data = dat[READ_LATENCY-1];
  assign read_data_valid = vld[READ_LATENCY-1];
  assign mem_ready = ready;
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed checks of main_memory with DEPTH_WORDS=16, READ_LATENCY=2.
module tb_main_memory;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] read_address = '0, write_address = '0, write_data = '0;
  logic write_enable = 1'b0;
  logic [31:0] read_data;
  logic read_data_valid, mem_ready, misaligned_error, bounds_error;
  int checks = 0, errors = 0;

  main_memory #(.DEPTH_WORDS(16), .READ_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .read_address(read_address), .write_address(write_address),
    .write_data(write_data), .write_enable(write_enable), .read_data(read_data),
    .read_data_valid(read_data_valid), .mem_ready(mem_ready),
    .misaligned_error(misaligned_error), .bounds_error(bounds_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    write_enable = 1'b1;
    write_address = a;
    write_data = d;
    cyc();
    write_enable = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    read_address = a;
    cyc();
    cyc();
    chk({tag, "_v"}, 32'(read_data_valid), 32'd1);
    chk(tag, read_data, exp);
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_valid", 32'(read_data_valid), 32'd0);
    chk("rst_data", read_data, 32'd0);
    chk("rst_errs", {30'd0, misaligned_error, bounds_error}, 32'd0);
    rst_n = 1'b1;
    repeat (7) cyc();
    rst_n = 1'b0;
    #1;
    chk("midinit_ready", 32'(mem_ready), 32'd0);
    cyc();
    rst_n = 1'b1;
    write_enable = 1'b1;
    write_address = 32'h4;
    write_data = 32'h5A5A5A5A;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk($sformatf("init_ready_%0d", i), 32'(mem_ready), 32'(i == 16));
      chk($sformatf("init_valid_%0d", i), 32'(read_data_valid), 32'd0);
    end
    write_enable = 1'b0;
    cyc();
    chk("lat_first_1", 32'(read_data_valid), 32'd0);
    cyc();
    chk("lat_first_2", 32'(read_data_valid), 32'd1);
    for (int w = 0; w < 16; w++) rd($sformatf("clear_%0d", w), 32'(4 * w), 32'd0);

    wr(32'h8, 32'hDEADBEEF);
    rd("rd_8", 32'h8, 32'hDEADBEEF);

    write_enable = 1'b1;
    write_address = 32'h10;
    write_data = 32'h12345678;
    read_address = 32'h10;
    cyc();
    write_data = 32'h0;
    read_address = 32'h0;
    cyc();
    write_enable = 1'b0;
    chk("wfirst", read_data, 32'h12345678);
    rd("rd_10_after", 32'h10, 32'h0);

    wr(32'h6, 32'hAAAA5555);
    chk("mis_wr_pulse", 32'(misaligned_error), 32'd1);
    cyc();
    chk("mis_wr_clear", 32'(misaligned_error), 32'd0);
    rd("mis_wr_drop", 32'h4, 32'h0);
    wr(32'h4, 32'h11111111);
    read_address = 32'h5;
    cyc();
    chk("mis_rd_pulse", 32'(misaligned_error), 32'd1);
    read_address = 32'h4;
    cyc();
    chk("mis_rd_data", read_data, 32'h11111111);
    cyc();
    chk("mis_rd_clear", 32'(misaligned_error), 32'd0);
    read_address = 32'h1;
    write_enable = 1'b1;
    write_address = 32'h2;
    write_data = 32'h77;
    cyc();
    write_enable = 1'b0;
    read_address = 32'h0;
    chk("mis_both_pulse", 32'(misaligned_error), 32'd1);
    cyc();
    chk("mis_both_single", 32'(misaligned_error), 32'd0);

    for (int k = 0; k < 4; k++) wr(32'(4 * k), 32'(k + 1));
    read_address = 32'h0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      read_address = 32'(4 * (k + 1));
      cyc();
      chk($sformatf("stream_v_%0d", k), 32'(read_data_valid), 32'd1);
      chk($sformatf("stream_d_%0d", k), read_data, 32'(k + 1));
    end

    wr(32'h0, 32'h0);
    wr(32'h40, 32'hFFFFFFFF);
`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
    chk("oob_wr_pulse", 32'(bounds_error), 32'd1);
    rd("oob_wr_drop", 32'h0, 32'h0);
    read_address = 32'h40;
    cyc();
    chk("oob_rd_pulse", 32'(bounds_error), 32'd1);
    cyc();
    chk("oob_rd_v", 32'(read_data_valid), 32'd1);
    chk("oob_rd_data", read_data, 32'h0);
`else
    chk("alias_no_bounds", 32'(bounds_error), 32'd0);
    rd("alias_rd_0", 32'h0, 32'hFFFFFFFF);
    rd("alias_rd_40", 32'h40, 32'hFFFFFFFF);
    chk("alias_no_bounds_rd", 32'(bounds_error), 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
